alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer.sv | 142 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: accepts one MIPS instruction at a time, drives a
// registered ALU operand/opcode set, waits ALU_LAT cycles for the result and
// presents it on a valid/ready response port. Illegal instructions bypass the
// ALU and respond immediately with the illegal flag set.
module alu_op_sequencer #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  // request side
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] a_data,
  input  logic [31:0] b_data,
  // ALU drive
  output logic [5:0]  opcode,
  output logic [5:0]  func_field,
  output logic [31:0] A,
  output logic [31:0] B,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  // response side
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_zero,
  output logic        out_branch_taken,
  output logic        out_illegal,
  output logic [15:0] op_count
);

  localparam logic [5:0] OpRType = 6'h00;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  // Counter compares against LAT-1 because it starts at 0 on the first EXEC edge.
  localparam logic [2:0] LastCnt = 3'(ALU_LAT - 1);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e      state_q;
  logic [2:0]  exec_cnt_q;

  logic [5:0]  in_op;
  logic [5:0]  in_fn;
  logic        is_legal;
  logic        is_mem;
  logic [31:0] imm_sext;

  // Register fields [25:16] carry no information for the sequencer.
  logic unused_instr;
  assign unused_instr = ^instr[25:16];

  assign in_op    = instr[31:26];
  assign in_fn    = instr[5:0];
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};
  assign is_mem   = (in_op == OpLw) || (in_op == OpSw);

  // Instruction legality decode.
  always_comb begin
    is_legal = 1'b0;
    case (in_op)
      OpRType: begin
        case (in_fn)
          FnAdd, FnSub, FnAnd, FnOr, FnSlt: is_legal = 1'b1;
          default:                          is_legal = 1'b0;
        endcase
      end
      OpLw, OpSw, OpBeq: is_legal = 1'b1;
      default:           is_legal = 1'b0;
    endcase
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StResp);

  // Sequencer FSM with registered ALU drive and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      exec_cnt_q       <= 3'd0;
      opcode           <= 6'd0;
      func_field       <= 6'd0;
      A                <= 32'd0;
      B                <= 32'd0;
      out_result       <= 32'd0;
      out_zero         <= 1'b0;
      out_branch_taken <= 1'b0;
      out_illegal      <= 1'b0;
      op_count         <= 16'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            if (is_legal) begin
              opcode     <= in_op;
              func_field <= (in_op == OpRType) ? in_fn : 6'd0;
              A          <= a_data;
              B          <= is_mem ? imm_sext : b_data;
              exec_cnt_q <= 3'd0;
              state_q    <= StExec;
            end else begin
              // ALU drive intentionally untouched on an illegal request.
              out_result       <= 32'd0;
              out_zero         <= 1'b0;
              out_branch_taken <= 1'b0;
              out_illegal      <= 1'b1;
              state_q          <= StResp;
            end
          end
        end
        StExec: begin
          if (exec_cnt_q == LastCnt) begin
            out_result       <= alu_result;
            out_zero         <= alu_zero;
            out_branch_taken <= (opcode == OpBeq) && alu_zero;
            out_illegal      <= 1'b0;
            state_q          <= StResp;
          end else begin
            exec_cnt_q <= exec_cnt_q + 3'd1;
          end
        end
        StResp: begin
          if (out_ready) begin
            op_count <= op_count + 16'd1;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: a latency-1 instance exercises the
// instruction set, stall and wrap behaviour; a latency-4 instance exercises
// latency and asynchronous abort.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // latency-1 instance
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr, a_data, b_data, A, B, alu_result, out_result;
  logic [5:0]  opcode, func_field;
  logic        alu_zero, out_zero, out_branch_taken, out_illegal;
  logic [15:0] op_count;

  // latency-4 instance
  logic        in_valid4, in_ready4, out_valid4, out_ready4;
  logic [31:0] instr4, a_data4, b_data4, A4, B4, alu_result4, out_result4;
  logic [5:0]  opcode4, func_field4;
  logic        alu_zero4, out_zero4, out_branch_taken4, out_illegal4;
  logic [15:0] op_count4;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        br;
    logic        ill;
  } exp_t;
  exp_t sb[$];

  // Behavioural ALU standing in for the real datapath.
  function automatic logic [31:0] alu_model(logic [5:0] op, logic [5:0] fn,
                                            logic [31:0] a, logic [31:0] b);
    if (op == 6'h00) begin
      case (fn)
        6'h20:   return a + b;
        6'h22:   return a - b;
        6'h24:   return a & b;
        6'h25:   return a | b;
        6'h2A:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        default: return 32'd0;
      endcase
    end else if (op == 6'h04) begin
      return a - b;
    end
    return a + b;
  endfunction

  assign alu_result  = alu_model(opcode, func_field, A, B);
  assign alu_zero    = (alu_result == 32'd0);
  assign alu_result4 = alu_model(opcode4, func_field4, A4, B4);
  assign alu_zero4   = (alu_result4 == 32'd0);

  alu_op_sequencer #(.ALU_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .a_data(a_data), .b_data(b_data),
    .opcode(opcode), .func_field(func_field), .A(A), .B(B),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_branch_taken(out_branch_taken),
    .out_illegal(out_illegal), .op_count(op_count)
  );

  alu_op_sequencer #(.ALU_LAT(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4), .instr(instr4),
    .a_data(a_data4), .b_data(b_data4),
    .opcode(opcode4), .func_field(func_field4), .A(A4), .B(B4),
    .alu_result(alu_result4), .alu_zero(alu_zero4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_result(out_result4),
    .out_zero(out_zero4), .out_branch_taken(out_branch_taken4),
    .out_illegal(out_illegal4), .op_count(op_count4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one instruction to the latency-1 instance and retire its response.
  task automatic do_op(input string tag, input logic [31:0] i_instr,
                       input logic [31:0] i_a, input logic [31:0] i_b,
                       input logic [5:0] e_op, input logic [5:0] e_fn,
                       input logic [31:0] e_a, input logic [31:0] e_b,
                       input logic [31:0] e_res, input logic e_zero,
                       input logic e_br, input logic e_ill,
                       input logic [15:0] e_cnt);
    exp_t e;
    int n;
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    instr    = i_instr;
    a_data   = i_a;
    b_data   = i_b;
    sb.push_back('{res: e_res, zero: e_zero, br: e_br, ill: e_ill});
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    instr    = $urandom;
    a_data   = $urandom;
    b_data   = $urandom;
    check({tag, ".opcode"}, 32'(opcode), 32'(e_op));
    check({tag, ".func_field"}, 32'(func_field), 32'(e_fn));
    check({tag, ".A"}, A, e_a);
    check({tag, ".B"}, B, e_b);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".latency"}, 32'(n), e_ill ? 32'd0 : 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, ".out_result"}, out_result, e.res);
      check({tag, ".out_zero"}, 32'(out_zero), 32'(e.zero));
      check({tag, ".out_branch_taken"}, 32'(out_branch_taken), 32'(e.br));
      check({tag, ".out_illegal"}, 32'(out_illegal), 32'(e.ill));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".out_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, ".op_count"}, 32'(op_count), 32'(e_cnt));
    check({tag, ".result_kept"}, out_result, e_res);
  endtask

  initial begin
    exp_t e;
    int n;
    logic [31:0] held;
    in_valid = 0; out_ready = 0; instr = 0; a_data = 0; b_data = 0;
    in_valid4 = 0; out_ready4 = 0; instr4 = 0; a_data4 = 0; b_data4 = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.opcode", 32'(opcode), 32'd0);
    check("rst.A", A, 32'd0);
    check("rst.out_result", out_result, 32'd0);
    check("rst.op_count", 32'(op_count), 32'd0);
    rst_n = 1'b1;

    do_op("add", 32'h0022_1820, 32'h2222, 32'h1111, 6'h00, 6'h20, 32'h2222, 32'h1111,
          32'h3333, 1'b0, 1'b0, 1'b0, 16'd1);
    do_op("beq", 32'h1022_0004, 32'h5555, 32'h5555, 6'h04, 6'h00, 32'h5555, 32'h5555,
          32'h0, 1'b1, 1'b1, 1'b0, 16'd2);
    do_op("lw", 32'h8C22_FFFC, 32'h1000, 32'hDEAD, 6'h23, 6'h00, 32'h1000, 32'hFFFF_FFFC,
          32'h0FFC, 1'b0, 1'b0, 1'b0, 16'd3);
    do_op("sw", 32'hAC22_0010, 32'h0100, 32'hBEEF, 6'h2B, 6'h00, 32'h0100, 32'h10,
          32'h0110, 1'b0, 1'b0, 1'b0, 16'd4);
    do_op("sub", 32'h0022_1822, 32'h5, 32'h7, 6'h00, 6'h22, 32'h5, 32'h7,
          32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 16'd5);
    do_op("slt", 32'h0022_182A, 32'h1111, 32'h2222, 6'h00, 6'h2A, 32'h1111, 32'h2222,
          32'h1, 1'b0, 1'b0, 1'b0, 16'd6);
    // Illegal funct: drive must still show the previous slt operands.
    do_op("ill_fn", 32'h0022_1803, 32'h9999, 32'h8888, 6'h00, 6'h2A, 32'h1111, 32'h2222,
          32'h0, 1'b0, 1'b0, 1'b1, 16'd7);
    do_op("ill_op", 32'hFC00_0000, 32'h1, 32'h2, 6'h00, 6'h2A, 32'h1111, 32'h2222,
          32'h0, 1'b0, 1'b0, 1'b1, 16'd8);

    // Backpressure: response held 5 cycles while a second request is offered.
    in_valid = 1'b1; instr = 32'h0022_1824; a_data = 32'hF0F0; b_data = 32'h0FF0;
    sb.push_back('{res: 32'h00F0, zero: 1'b0, br: 1'b0, ill: 1'b0});
    @(posedge clk);
    @(negedge clk);
    instr = 32'h0022_1825; a_data = 32'h1234; b_data = 32'h4321;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("stall.latency", 32'(n), 32'd1);
    held = out_result;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall.out_valid", 32'(out_valid), 32'd1);
      check("stall.in_ready", 32'(in_ready), 32'd0);
      check("stall.out_result", out_result, held);
      check("stall.func_field", 32'(func_field), 32'h24);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("stall.result", out_result, e.res);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    check("stall.op_count", 32'(op_count), 32'd9);
    check("stall.in_ready", 32'(in_ready), 32'd1);
    check("stall.A_no_second_op", A, 32'hF0F0);

    // Latency-4 instance: one full operation.
    in_valid4 = 1'b1; instr4 = 32'h0022_1820; a_data4 = 32'h10; b_data4 = 32'h20;
    @(posedge clk);
    @(negedge clk);
    in_valid4 = 1'b0;
    n = 0;
    while (!out_valid4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("lat4.latency", 32'(n), 32'd4);
    check("lat4.out_result", out_result4, 32'h30);
    out_ready4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready4 = 1'b0;
    check("lat4.op_count", 32'(op_count4), 32'd1);

    // Abort mid-EXEC with an asynchronous reset between clock edges.
    in_valid4 = 1'b1; instr4 = 32'h0022_1822; a_data4 = 32'h77; b_data4 = 32'h11;
    @(posedge clk);
    @(negedge clk);
    in_valid4 = 1'b0; out_ready4 = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort.out_valid", 32'(out_valid4), 32'd0);
    check("abort.in_ready", 32'(in_ready4), 32'd1);
    check("abort.opcode", 32'(opcode4), 32'd0);
    check("abort.func_field", 32'(func_field4), 32'd0);
    check("abort.A", A4, 32'd0);
    check("abort.B", B4, 32'd0);
    check("abort.out_result", out_result4, 32'd0);
    check("abort.op_count", 32'(op_count4), 32'd0);
    check("abort.dut1_op_count", 32'(op_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("abort.no_resp", 32'(out_valid4), 32'd0);
    check("abort.count_held", 32'(op_count4), 32'd0);
    out_ready4 = 1'b0;

    // op_count wrap: back-to-back illegal ops take two edges each.
    in_valid = 1'b1; instr = 32'hFC00_0000; out_ready = 1'b1;
    repeat (2 * 65535) @(posedge clk);
    @(negedge clk);
    check("wrap.ffff", 32'(op_count), 32'hFFFF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("wrap.zero", 32'(op_count), 32'h0);
    in_valid = 1'b0; out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
